// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types for the 4x4 keypad scanner.
// Holds the debounce FSM state encoding, the frame-class encoding,
// the key-code width and the per-frame payload handed from scan to debounce.
// Optional feature (see keypad_scan): KEYPAD_SCAN_EVENT_EN.
package keypad_pkg;

    localparam int unsigned KEY_W    = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_ROWS = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_REL_DB   = 2'd3
    } db_state_e;

    typedef enum logic [1:0] {
        FC_NONE   = 2'd0,
        FC_SINGLE = 2'd1,
        FC_MULTI  = 2'd2
    } frame_class_e;

    // One completed scan frame; valid pulses for a single cycle.
    typedef struct packed {
        logic               valid;
        frame_class_e       cls;
        logic [KEY_W-1:0]   key;
    } frame_t;

    // Number of low (pressed) row bits, saturated at 2.
    function automatic logic [1:0] low_count(input logic [NUM_ROWS-1:0] r);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < int'(NUM_ROWS); i++) begin
            n = n + 3'(~r[i]);
        end
        return (n >= 3'd2) ? 2'd2 : n[1:0];
    endfunction

    // Index of the lowest low row bit (only meaningful when one bit is low).
    function automatic logic [1:0] low_index(input logic [NUM_ROWS-1:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = int'(NUM_ROWS) - 1; i >= 0; i--) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level debounce FSM for the keypad scanner.
// Ports:
//   clk_i, rst_i  - system clock, synchronous active-high reset
//   frame_i       - completed frame (valid pulse, class, key code)
//   pressed_o     - high while a debounced key is held (registered)
//   key_o         - code of the last accepted key (registered)
//   event_o       - one-cycle pulse on press acceptance (KEYPAD_SCAN_EVENT_EN only)
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  frame_t           frame_i,
    output logic             pressed_o,
    output logic [KEY_W-1:0] key_o
`ifdef KEYPAD_SCAN_EVENT_EN
    ,
    output logic             event_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic             pressed_q, pressed_d;
    logic [KEY_W-1:0] key_q, key_d;

    // Next-state logic, evaluated only on a frame-end pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        pressed_d = pressed_q;
        key_d     = key_q;
        if (frame_i.valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_i.cls == FC_SINGLE) begin
                        cand_d = frame_i.key;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d   = ST_PRESSED;
                            cnt_d     = '0;
                            pressed_d = 1'b1;
                            key_d     = frame_i.key;
                        end else begin
                            state_d = ST_PRESS_DB;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (frame_i.cls == FC_SINGLE && frame_i.key == cand_q) begin
                        if (cnt_q >= CNT_LAST) begin
                            state_d   = ST_PRESSED;
                            cnt_d     = '0;
                            pressed_d = 1'b1;
                            key_d     = cand_q;
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (frame_i.cls == FC_NONE) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d   = ST_IDLE;
                            cnt_d     = '0;
                            pressed_d = 1'b0;
                        end else begin
                            state_d = ST_REL_DB;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_REL_DB: begin
                    if (frame_i.cls == FC_NONE) begin
                        if (cnt_q >= CNT_LAST) begin
                            state_d   = ST_IDLE;
                            cnt_d     = '0;
                            pressed_d = 1'b0;
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cand_q    <= '0;
            pressed_q <= 1'b0;
            key_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            pressed_q <= pressed_d;
            key_q     <= key_d;
        end
    end

    assign pressed_o = pressed_q;
    assign key_o     = key_q;

`ifdef KEYPAD_SCAN_EVENT_EN
    logic event_q;

    // Rising edge of the debounced press, aligned with pressed_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) event_q <= 1'b0;
        else       event_q <= pressed_d & ~pressed_q;
    end

    assign event_o = event_q;
`endif

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame debounce.
// Drives one active-low column at a time, samples rows at the end of each
// column period, classifies every 4-column frame and debounces it.
// Ports:
//   sys_clk, sys_rst - system clock, synchronous active-high reset
//   row              - keypad rows, active-low
//   col              - column drive, active-low one-hot (registered)
//   IsPressed        - debounced key held
//   keyboard_data    - code (row*4 + col) of the last accepted key
//   key_event        - one-cycle pulse on acceptance (only with KEYPAD_SCAN_EVENT_EN)
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_FRAMES = 5
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic                IsPressed,
    output logic [KEY_W-1:0]    keyboard_data
`ifdef KEYPAD_SCAN_EVENT_EN
    ,
    output logic                key_event
`endif
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0]    div_q, div_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0] col_q, col_d;
    logic [1:0]          acc_q, acc_d;     // saturating low count within the frame
    logic [KEY_W-1:0]    key_q, key_d;     // key seen by the last single-low sample
    frame_t              frame_q, frame_d;

    logic [1:0]          lows;
    logic [1:0]          base;
    logic [2:0]          sum3;
    logic [1:0]          sum;
    logic [KEY_W-1:0]    key_now;

    // Column rotation, row sampling and frame classification.
    always_comb begin
        div_d     = div_q;
        col_idx_d = col_idx_q;
        col_d     = col_q;
        acc_d     = acc_q;
        key_d     = key_q;
        frame_d   = '0;
        lows      = low_count(row);
        base      = (col_idx_q == 2'd0) ? 2'd0 : acc_q;
        sum3      = 3'(base) + 3'(lows);
        sum       = (sum3 >= 3'd2) ? 2'd2 : sum3[1:0];
        key_now   = {low_index(row), col_idx_q};
        if (div_q == DIV_LAST) begin
            div_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = ~(NUM_COLS'(1) << col_idx_d);
            acc_d     = sum;
            if (lows == 2'd1) key_d = key_now;
            if (col_idx_q == 2'd3) begin
                frame_d.valid = 1'b1;
                frame_d.key   = (lows == 2'd1) ? key_now : key_q;
                case (sum)
                    2'd0:    frame_d.cls = FC_NONE;
                    2'd1:    frame_d.cls = FC_SINGLE;
                    default: frame_d.cls = FC_MULTI;
                endcase
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_q     <= '0;
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
            acc_q     <= 2'd0;
            key_q     <= '0;
            frame_q   <= '0;
        end else begin
            div_q     <= div_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            acc_q     <= acc_d;
            key_q     <= key_d;
            frame_q   <= frame_d;
        end
    end

    assign col = col_q;

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .frame_i  (frame_q),
        .pressed_o(IsPressed),
        .key_o    (keyboard_data)
`ifdef KEYPAD_SCAN_EVENT_EN
        ,
        .event_o  (key_event)
`endif
    );

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with SCAN_DIV=4,
// DEBOUNCE_FRAMES=3 (frame ends at cycles 16, 32, 48, ... after reset release).
// A keypad model pulls a row low when a held key's column is driven low.
module tb_keypad_scan;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        IsPressed;
    logic [3:0]  keyboard_data;
    logic [15:0] held = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

`ifdef KEYPAD_SCAN_EVENT_EN
    logic key_event;
    int   ev_cnt = 0;
    always @(posedge sys_clk) if (key_event === 1'b1) ev_cnt <= ev_cnt + 1;
`endif

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_FRAMES(3)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .row          (row),
        .col          (col),
        .IsPressed    (IsPressed),
        .keyboard_data(keyboard_data)
`ifdef KEYPAD_SCAN_EVENT_EN
        ,
        .key_event    (key_event)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Keypad matrix: key r*4+c shorts row r to column c.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // One reset edge, then release; cycle count restarts at 0.
    task automatic pulse_reset();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        // Reset state and column rotation
        pulse_reset();
        check("rst_col", 32'(col), 32'h E);
        check("rst_pressed", 32'(IsPressed), 32'd0);
        check("rst_data", 32'(keyboard_data), 32'd0);
        run_to(3);
        check("col0_hold", 32'(col), 32'h E);
        run_to(4);
        check("col1_at4", 32'(col), 32'h D);
        run_to(8);
        check("col2_at8", 32'(col), 32'h B);
        run_to(16);
        check("col0_wrap", 32'(col), 32'h E);

        // Key 6 held from reset release -> accepted at cycle 49
        held = 16'h0040;
        pulse_reset();
        run_to(48);
        check("k6_not_yet", 32'(IsPressed), 32'd0);
        run_to(49);
        check("k6_pressed", 32'(IsPressed), 32'd1);
        check("k6_data", 32'(keyboard_data), 32'd6);
`ifdef KEYPAD_SCAN_EVENT_EN
        check("k6_event_hi", 32'(key_event), 32'd1);
        run_to(50);
        check("k6_event_lo", 32'(key_event), 32'd0);
`endif

        // Release: NONE frames end at 64, 80, 96 -> falls at 97
        held = 16'h0000;
        run_to(96);
        check("rel_still", 32'(IsPressed), 32'd1);
        run_to(97);
        check("rel_fall", 32'(IsPressed), 32'd0);
        check("rel_data_hold", 32'(keyboard_data), 32'd6);

        // Key 6 bouncing frame by frame never gets accepted
        pulse_reset();
        for (int f = 0; f < 10; f++) begin
            held = (f % 2 == 0) ? 16'h0040 : 16'h0000;
            run_to(16 * (f + 1));
            tick();
            check("bounce_pressed", 32'(IsPressed), 32'd0);
            cyc--;
        end
        check("bounce_data", 32'(keyboard_data), 32'd0);
        held = 16'h0000;

        // Keys 3+12 together are rejected; then key 5, then key 9 added
        pulse_reset();
        held = 16'h1008;
        run_to(64);
        held = 16'h0020;
        run_to(65);
        check("multi_rej", 32'(IsPressed), 32'd0);
        check("multi_data", 32'(keyboard_data), 32'd0);
        run_to(112);
        check("k5_not_yet", 32'(IsPressed), 32'd0);
        run_to(113);
        check("k5_pressed", 32'(IsPressed), 32'd1);
        check("k5_data", 32'(keyboard_data), 32'd5);
        held = 16'h0220;
        run_to(177);
        check("k5k9_pressed", 32'(IsPressed), 32'd1);
        check("k5k9_data", 32'(keyboard_data), 32'd5);
        held = 16'h0000;

        // Reset during PRESS_DB discards the candidate
        held = 16'h0040;
        pulse_reset();
        run_to(40);
        sys_rst = 1'b1;
        tick();
        check("rstdb_pressed", 32'(IsPressed), 32'd0);
        check("rstdb_data", 32'(keyboard_data), 32'd0);
        check("rstdb_col", 32'(col), 32'h E);
        sys_rst = 1'b0;
        cyc = 0;
        run_to(17);
        check("rstdb_no_carry", 32'(IsPressed), 32'd0);
        run_to(48);
        check("rstdb_not_yet", 32'(IsPressed), 32'd0);
        run_to(49);
        check("rstdb_pressed2", 32'(IsPressed), 32'd1);
        check("rstdb_data2", 32'(keyboard_data), 32'd6);

        // Reset during PRESSED
        run_to(60);
        sys_rst = 1'b1;
        tick();
        check("rstpr_pressed", 32'(IsPressed), 32'd0);
        check("rstpr_data", 32'(keyboard_data), 32'd0);
        check("rstpr_col", 32'(col), 32'h E);
        sys_rst = 1'b0;
        held = 16'h0000;
        cyc = 0;
        run_to(8);

`ifdef KEYPAD_SCAN_EVENT_EN
        // Accepted presses: key 6, key 5, key 6 after reset
        check("event_count", 32'(ev_cnt), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each column is driven (1 ms at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 5, consecutive identical scan frames required to accept a press or release; legal range >= 1.
REQ-003 SHALL have port sys_clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port row, input, 4 bits: keypad rows, active-low, externally pulled up.
REQ-006 SHALL have port col, output, 4 bits: keypad column drive, active-low one-hot.
REQ-007 SHALL have port IsPressed, output, 1 bit: high while a debounced key is held.
REQ-008 SHALL have port keyboard_data, output, 4 bits: code of the last accepted key.

Function
REQ-009 SHALL drive col 1110, 1101, 1011, 0111 in rotation, holding each value for SCAN_DIV cycles.
REQ-010 SHALL sample row only in the last cycle of each column period (div count = SCAN_DIV-1), leaving settling time.
REQ-011 SHALL treat a frame as the four samples of columns 0..3, ending on the column-3 sample cycle.
REQ-012 SHALL encode the pressed key as row_index*4 + col_index (row0/col0 = 0, row3/col3 = 15).
REQ-013 SHALL classify each frame as NONE (no low bit), SINGLE(k) (exactly one low bit over all four samples), or MULTI (two or more).
REQ-014 SHALL implement FSM states IDLE, PRESS_DB, PRESSED, REL_DB, evaluated once per frame end.
REQ-015 IDLE: SINGLE(k) -> latch candidate k, stable count = 1, go to PRESS_DB (accept immediately if DEBOUNCE_FRAMES = 1); NONE or MULTI -> stay.
REQ-016 PRESS_DB: SINGLE(same k) -> increment count; on reaching DEBOUNCE_FRAMES go to PRESSED; any other class -> IDLE, count cleared.
REQ-017 On entry to PRESSED, IsPressed SHALL be 1 and keyboard_data SHALL equal k, both on the cycle after the accepting frame end.
REQ-018 PRESSED: NONE -> REL_DB with count = 1; SINGLE (any key) or MULTI -> stay, outputs unchanged.
REQ-019 REL_DB: NONE -> increment count; on reaching DEBOUNCE_FRAMES go to IDLE and IsPressed = 0 next cycle; SINGLE or MULTI -> PRESSED.
REQ-020 keyboard_data SHALL hold its value after release until the next accepted press.
REQ-021 Counters SHALL saturate and never wrap; the column index SHALL wrap 3 -> 0.

Reset
REQ-022 While sys_rst is high at a clock edge, the next state SHALL be: col = 1110, IsPressed = 0, keyboard_data = 0, FSM = IDLE, all counters = 0.
REQ-023 Reset asserted mid-frame or mid-debounce SHALL discard the partial frame and candidate; scanning SHALL restart at column 0 on the first cycle after release.

Configuration
REQ-024 With KEYPAD_SCAN_EVENT_EN defined, the block SHALL add output key_event (1 bit), pulsing high for exactly one cycle, coincident with the rising edge of IsPressed.
REQ-025 Without KEYPAD_SCAN_EVENT_EN, the key_event port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 The shared package keypad_pkg SHALL hold the FSM state encoding, the frame-class encoding, and the key-code width constant (4).
REQ-027 The block SHALL be split into scan/sample logic in keypad_scan and a sub-module keypad_debounce (frame class in, IsPressed/keyboard_data out).

Verification
All scenarios use SCAN_DIV = 4 and DEBOUNCE_FRAMES = 3 (frame = 16 cycles; frame ends at cycles 16, 32, 48, ... after reset release).
REQ-028 Reset, no key held -> col = 1110, IsPressed = 0, keyboard_data = 0; col advances to 1101 at cycle 4.
REQ-029 Key 6 (row1 low while col2 driven) held from reset release -> IsPressed = 1 and keyboard_data = 6 at cycle 49.
REQ-030 Key 6 alternating one frame pressed, one frame released, for 10 frames -> IsPressed stays 0 and keyboard_data stays 0.
REQ-031 Key 6 accepted, then released -> IsPressed falls one cycle after the third consecutive NONE frame; keyboard_data stays 6.
REQ-032 Keys 3 and 12 pressed together from IDLE -> no acceptance; key 5 accepted, then key 9 added -> IsPressed stays 1 and keyboard_data stays 5.
REQ-033 sys_rst pulsed during PRESS_DB, and also during PRESSED -> next cycle IsPressed = 0, keyboard_data = 0, col = 1110; with KEYPAD_SCAN_EVENT_EN defined, key_event pulses once per accepted press.
